display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
// Time-multiplexes one hex-to-seven-segment decoder across a 4-digit common-anode display.
// Holds a 16-bit value as four hex nibbles.
// Each slot, it drives one nibble to the decoder and enables that digit's anode (active-low).
// A blanking guard at the start of each slot prevents ghosting.
// New values arrive through a valid/ready handshake and take effect only at a frame boundary (no tearing).
// PARAMETERS
// SLOT_CYCLES   100_000  clk cycles per digit slot (1 kHz per slot at 100 MHz); must be > BLANK_CYCLES
// BLANK_CYCLES  1_000    cycles at slot start with all anodes off; must be >= 1
// NDIG          4        digits per frame (fixed at 4; parameter for package use only)
// PORTS
// clk          in   1   system clock, rising edge
// reset_n      in   1   asynchronous active-low reset
// value_in     in   16  four hex nibbles; [3:0] = digit 0 (rightmost)
// value_valid  in   1   value_in offered this cycle
// value_ready  out  1   controller can accept value_in
// digit_en     in   4   per-digit enable; 0 keeps that anode off during its slot
// lz_blank     in   1   1 = suppress leading zeros
// bcd_out      out  4   nibble to decoder input
// anode_n      out  4   active-low anode selects; bit i = digit i
// frame_start  out  1   one-cycle pulse when slot 0 blanking begins
// BEHAVIOUR
// - Reset values:
//   - anode_n=4'b1111, bcd_out=0, value_ready=1, frame_start=0.
//   - Shadow and pending registers are 0; digit index is 0; state BLANK; slot counter 0.
// - All outputs are registered. Reset may assert at any time and forces reset values immediately.
// - Slot timing:
//   - Counter runs 0..SLOT_CYCLES-1; it wraps to 0 and the digit index increments mod 4 (3 -> 0).
//   - FSM states: BLANK (count < BLANK_CYCLES) and SHOW (count >= BLANK_CYCLES).
//   - Transitions: BLANK -> SHOW when count == BLANK_CYCLES-1; SHOW -> BLANK when count == SLOT_CYCLES-1.
// - BLANK:
//   - anode_n=1111.
//   - bcd_out is updated to the next digit's nibble on the first BLANK cycle, so decoder settling is hidden.
// - SHOW:
//   - anode_n has only bit idx low, and only if the digit is visible; otherwise 1111.
//   - Visible = digit_en[idx] && !lz_suppressed(idx).
// - Leading-zero suppression (lz_blank=1):
//   - Digit i (i = 3..1) is suppressed iff nibbles i..3 of the shadow value are all 0.
//   - Digit 0 is never suppressed, so value 0 shows "0".
// - Handshake:
//   - Transfer occurs when value_valid && value_ready; value_in is captured into the pending register.
//   - value_ready drops the following cycle.
//   - At frame boundary (SHOW->BLANK with idx 3->0), pending is copied to shadow and value_ready returns to 1 next cycle.
//   - With no pending value, shadow is unchanged at the boundary.
//   - A transfer on the boundary cycle itself is captured to pending and applies at the next boundary.
// - frame_start: high for exactly the first BLANK cycle of digit 0, including the first frame after reset.
// - digit_en and lz_blank are sampled every cycle (combinational into the registered anode_n); changes take effect next cycle.
// - Widths: counter width is $clog2(SLOT_CYCLES); idx is 2 bits with natural wrap.
// STRUCTURE
// - Package disp_pkg:
//   - typedef enum logic {BLANK, SHOW} scan_state_t;
//   - localparam NDIG=4;
//   - localparam logic [3:0] ANODES_OFF=4'b1111;
//   - function onehot_n(idx) returning the active-low anode pattern.
// - Sub-module slot_timer:
//   - Parameterized counter (SLOT_CYCLES, BLANK_CYCLES).
//   - Outputs: in_blank, slot_end, blank_first.
//   - The controller instantiates it once.
// - The decoder is instantiated by the parent, fed from bcd_out; not inside this block.
// TESTING (bench uses SLOT_CYCLES=8, BLANK_CYCLES=2)
// 1. Reset released, value 16'h12AF loaded, digit_en=1111, lz_blank=0:
//    - anode_n cycles 1110,1101,1011,0111, each low for 6 of 8 cycles with 2 cycles of 1111 between.
//    - bcd_out reads F,A,2,1 respectively.
//    - frame_start pulses every 32 cycles.
// 2. value 16'h0070, lz_blank=1: digits 3 and 2 keep anode off; digits 1 and 0 show 7 and 0.
//    value 0 shows only digit 0 = 0.
// 3. Handshake:
//    - Load 16'h1111 mid-frame -> value_ready=0 and digits keep the old value until the boundary.
//    - Display switches to 1111 starting at digit 0; value_ready=1 one cycle after the boundary.
// 4. value_valid held high with 16'h2222 while ready=0 -> no capture.
//    - Transfer on the exact boundary cycle -> applied one frame later.
// 5. digit_en=0101: only digits 0 and 2 light; slot timing unchanged (frame still 32 cycles).
// 6. reset_n pulsed low mid-SHOW of digit 2:
//    - anode_n=1111 asynchronously; shadow becomes 0.
//    - After release the scan restarts at digit 0 with frame_start on the first cycle.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display scan controller.
//   scan_state_t : slot phase (BLANK guard, then SHOW)
//   NDIG         : digits per frame
//   ANODES_OFF   : active-low anode pattern with every digit dark
//   onehot_n     : active-low anode pattern selecting a single digit
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int NDIG = 4;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  function automatic logic [3:0] onehot_n(input logic [1:0] idx);
    onehot_n = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot timer for the display scan controller.
// Counts 0..SLOT_CYCLES-1 and tracks the BLANK/SHOW phase of the slot.
//   clk           : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   o_in_blank    : slot is in its blanking guard (count < BLANK_CYCLES)
//   o_slot_end    : last cycle of the slot (count == SLOT_CYCLES-1)
//   o_blank_first : first cycle of the slot (count == 0)
module slot_timer
  import disp_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic o_in_blank,
  output logic o_slot_end,
  output logic o_blank_first
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic             w_slot_end;

  assign w_slot_end = (r_cnt == LAST_SLOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_state <= BLANK;
    end else begin
      r_cnt   <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
      r_state <= w_state_nxt;
    end
  end

  // The phase register always agrees with count < BLANK_CYCLES; it is kept
  // as explicit state so the slot phase is visible by name.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   if (r_cnt == LAST_BLANK) w_state_nxt = SHOW;
      SHOW:    if (w_slot_end)          w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  assign o_in_blank    = (r_state == BLANK);
  assign o_slot_end    = w_slot_end;
  assign o_blank_first = (r_cnt == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes one hex-to-seven-segment decoder across a 4-digit
// common-anode display. Each slot starts with a blanking guard, then lights
// one digit. New values are accepted through valid/ready into a pending
// register and copied to the displayed (shadow) value only at a frame
// boundary, so a frame never mixes two values.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   value_in     : four hex nibbles, [3:0] = digit 0 (rightmost)
//   value_valid  : value_in offered this cycle
//   value_ready  : controller can accept value_in
//   digit_en     : per-digit enable, 0 keeps that anode off
//   lz_blank     : 1 = suppress leading zeros
//   bcd_out      : nibble to the external decoder
//   anode_n      : active-low anode selects, bit i = digit i
//   frame_start  : one-cycle pulse as slot 0 blanking begins
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  bcd_out,
  output logic [3:0]  anode_n,
  output logic        frame_start
);

  localparam int IDX_W = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  logic [15:0]      r_shadow;
  logic [15:0]      r_pending;
  logic             r_ready;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_bcd;
  logic [3:0]       r_anode_n;
  logic             r_frame_start;

  logic             w_in_blank;
  logic             w_slot_end;
  logic             w_blank_first;
  logic             w_visible;
  logic             w_frame_bnd;
  logic             w_xfer;
  logic [3:0]       w_anode_nxt;

  function automatic logic [3:0] nibble_sel(input logic [15:0] v,
                                            input logic [1:0]  i);
    case (i)
      2'd0:    nibble_sel = v[3:0];
      2'd1:    nibble_sel = v[7:4];
      2'd2:    nibble_sel = v[11:8];
      default: nibble_sel = v[15:12];
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 is never suppressed so that a zero value still shows "0".
  function automatic logic lz_suppressed(input logic [15:0] v,
                                         input logic [1:0]  i);
    case (i)
      2'd3:    lz_suppressed = (v[15:12] == 4'h0);
      2'd2:    lz_suppressed = (v[15:8]  == 8'h00);
      2'd1:    lz_suppressed = (v[15:4]  == 12'h000);
      default: lz_suppressed = 1'b0;
    endcase
  endfunction

  slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .o_in_blank    (w_in_blank),
    .o_slot_end    (w_slot_end),
    .o_blank_first (w_blank_first)
  );

  always_comb begin
    w_visible   = digit_en[r_idx] && !(lz_blank && lz_suppressed(r_shadow, r_idx));
    w_anode_nxt = (w_in_blank || !w_visible) ? ANODES_OFF : onehot_n(r_idx);
    w_frame_bnd = w_slot_end && (r_idx == LAST_IDX);
    w_xfer      = value_valid && r_ready;
  end

  // Output stage: every output is a register loaded from the current slot state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow      <= '0;
      r_pending     <= '0;
      r_ready       <= 1'b1;
      r_idx         <= '0;
      r_bcd         <= '0;
      r_anode_n     <= ANODES_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_anode_n     <= w_anode_nxt;
      r_frame_start <= w_blank_first && (r_idx == '0);

      // Switching the decoder input while all anodes are dark hides its settling.
      if (w_blank_first) r_bcd <= nibble_sel(r_shadow, r_idx);

      if (w_slot_end) r_idx <= r_idx + IDX_W'(1);

      // ready low means a pending value is waiting, so a transfer and a
      // pending-to-shadow copy can never coincide; a transfer landing on the
      // boundary cycle waits for the following boundary.
      if (w_xfer) begin
        r_pending <= value_in;
        r_ready   <= 1'b0;
      end else if (w_frame_bnd && !r_ready) begin
        r_shadow  <= r_pending;
        r_ready   <= 1'b1;
      end
    end
  end

  assign value_ready = r_ready;
  assign bcd_out     = r_bcd;
  assign anode_n     = r_anode_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  anode_n;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  den;
    logic        lz;
    logic [15:0] exp_an;  // expected SHOW anode pattern, [3:0] = digit 0
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  display_scan_controller #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .bcd_out     (bcd_out),
    .anode_n     (anode_n),
    .frame_start (frame_start)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int at,
                     input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, at, act, exp);
    end
  endtask

  // Checks one full frame starting at the frame_start cycle, then the
  // frame_start of the following frame.
  task automatic check_frame(input logic [15:0] val, input logic [15:0] exp_an);
    int d;
    int p;
    logic [3:0] ea;
    for (int j = 0; j < FRAME; j++) begin
      d  = j / SLOT;
      p  = j % SLOT;
      ea = (p < BLANK) ? 4'hF : exp_an[d*4 +: 4];
      chk("anode_n", j, 16'(anode_n), 16'(ea));
      chk("bcd_out", j, 16'(bcd_out), 16'(val[d*4 +: 4]));
      chk("frame_start", j, 16'(frame_start), (j == 0) ? 16'h1 : 16'h0);
      step;
    end
    chk("frame_len", FRAME, 16'(frame_start), 16'h1);
  endtask

  task automatic wait_fs;
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 3 * FRAME) begin
      step;
      n++;
    end
    chk("wait_frame_start", n, 16'(frame_start), 16'h1);
  endtask

  task automatic load(input logic [15:0] v);
    int n;
    n = 0;
    while (value_ready !== 1'b1 && n < 3 * FRAME) begin
      step;
      n++;
    end
    chk("load_ready", n, 16'(value_ready), 16'h1);
    value_in    = v;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    chk("ready_drop", 0, 16'(value_ready), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h12AF, 4'hF, 1'b0, 16'h7BDE};
    vecs[1] = '{16'h0070, 4'hF, 1'b1, 16'hFFDE};
    vecs[2] = '{16'h0000, 4'hF, 1'b1, 16'hFFFE};
    vecs[3] = '{16'h0000, 4'hF, 1'b0, 16'h7BDE};
    vecs[4] = '{16'h12AF, 4'h5, 1'b0, 16'hFBFE};
    vecs[5] = '{16'h0A05, 4'hF, 1'b1, 16'hFBDE};
    vecs[6] = '{16'h1000, 4'hF, 1'b1, 16'h7BDE};
    vecs[7] = '{16'h0070, 4'hE, 1'b1, 16'hFFDF};
    vecs[8] = '{16'h0070, 4'hF, 1'b0, 16'h7BDE};

    // Reset state
    #22;
    chk("rst_anode_n", 0, 16'(anode_n), 16'hF);
    chk("rst_bcd_out", 0, 16'(bcd_out), 16'h0);
    chk("rst_ready", 0, 16'(value_ready), 16'h1);
    chk("rst_frame_start", 0, 16'(frame_start), 16'h0);
    #1;
    reset_n = 1'b1;
    step;
    check_frame(16'h0000, 16'h7BDE);

    // Table-driven values, enables and zero suppression
    for (int i = 0; i < 9; i++) begin
      digit_en = vecs[i].den;
      lz_blank = vecs[i].lz;
      repeat (5) step;
      load(vecs[i].value);
      wait_fs;
      chk("ready_at_frame", i, 16'(value_ready), 16'h1);
      check_frame(vecs[i].value, vecs[i].exp_an);
    end

    // Mid-frame load: old value persists to the boundary, ready returns
    // the cycle after the boundary.
    repeat (10) step;
    chk("mid_ready_pre", 10, 16'(value_ready), 16'h1);
    value_in    = 16'h1111;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    for (int j = 11; j < FRAME; j++) begin
      chk("mid_old_bcd", j, 16'(bcd_out), 16'(vecs[8].value[(j/SLOT)*4 +: 4]));
      chk("mid_ready", j, 16'(value_ready), (j == FRAME - 1) ? 16'h1 : 16'h0);
      step;
    end
    chk("mid_frame_start", 0, 16'(frame_start), 16'h1);
    check_frame(16'h1111, 16'h7BDE);

    // valid held while not ready is ignored
    repeat (3) step;
    load(16'h3333);
    value_in    = 16'h2222;
    value_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("hold_ready", k, 16'(value_ready), 16'h0);
      step;
    end
    value_valid = 1'b0;
    repeat (12) step;
    chk("hold_frame_start", 0, 16'(frame_start), 16'h1);
    chk("hold_ready_back", 0, 16'(value_ready), 16'h1);
    check_frame(16'h3333, 16'h7BDE);

    // Transfer exactly on the boundary cycle applies one frame later
    repeat (FRAME - 2) step;
    chk("bnd_ready_pre", 0, 16'(value_ready), 16'h1);
    value_in    = 16'h4444;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    chk("bnd_ready_drop", 0, 16'(value_ready), 16'h0);
    step;
    chk("bnd_frame_start", 0, 16'(frame_start), 16'h1);
    chk("bnd_ready_held", 0, 16'(value_ready), 16'h0);
    check_frame(16'h3333, 16'h7BDE);
    chk("bnd_ready_back", 0, 16'(value_ready), 16'h1);
    check_frame(16'h4444, 16'h7BDE);

    // Asynchronous reset during SHOW of digit 2
    repeat (19) step;
    chk("pre_rst_anode_n", 19, 16'(anode_n), 16'hB);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_anode_n", 0, 16'(anode_n), 16'hF);
    chk("arst_bcd_out", 0, 16'(bcd_out), 16'h0);
    chk("arst_ready", 0, 16'(value_ready), 16'h1);
    chk("arst_frame_start", 0, 16'(frame_start), 16'h0);
    @(posedge clk);
    #3;
    chk("arst_hold_anode_n", 1, 16'(anode_n), 16'hF);
    reset_n = 1'b1;
    step;
    check_frame(16'h0000, 16'h7BDE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
